// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ==== instruction_fetch_if : PC, memory read port, decoder handshake and flush bundle ====
// ==== Rev 1.0                                                                         ====
interface instruction_fetch_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] PcValue;
   logic             PcStep;
   logic             MemReq;
   logic [WIDTH-1:0] MemAddr;
   logic             MemGrant;
   logic             MemRValid;
   logic [WIDTH-1:0] MemRData;
   logic             InstrValid;
   logic             InstrReady;
   logic [WIDTH-1:0] Instr;
   logic [WIDTH-1:0] InstrAddr;
   logic             Flush;

   modport master (
      input  PcValue,
      output PcStep,
      output MemReq,
      output MemAddr,
      input  MemGrant,
      input  MemRValid,
      input  MemRData,
      output InstrValid,
      input  InstrReady,
      output Instr,
      output InstrAddr,
      input  Flush
   );

   modport slave (
      output PcValue,
      input  PcStep,
      input  MemReq,
      input  MemAddr,
      output MemGrant,
      output MemRValid,
      output MemRData,
      input  InstrValid,
      output InstrReady,
      input  Instr,
      input  InstrAddr,
      output Flush
   );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ==== instruction_fetch : credit-based prefetcher with flush/drain of in-flight reads ====
// ==== Rev 1.0                                                                        ====
module instruction_fetch #(
   parameter int QUEUE_DEPTH = 2,
   parameter int WIDTH       = 16
) (
   input wire                  Clock,
   input wire                  nReset,
   instruction_fetch_if.master bus
);
   localparam int CW = $clog2(QUEUE_DEPTH + 1);
   localparam int AW = $clog2(QUEUE_DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(QUEUE_DEPTH);

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      STALL = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [AW-1:0] af_wr_q, af_wr_d, af_rd_q, af_rd_d;
   logic [AW-1:0] iq_wr_q, iq_wr_d, iq_rd_q, iq_rd_d;

   logic [WIDTH-1:0] af_mem  [QUEUE_DEPTH];
   logic [WIDTH-1:0] iq_data [QUEUE_DEPTH];
   logic [WIDTH-1:0] iq_addr [QUEUE_DEPTH];

   logic          credit, credit_next;
   logic          mem_req, grant, rsp, push, pop, instr_valid;
   logic [CW-1:0] in_flight_net;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(QUEUE_DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Reserving a slot at request time means every granted response has a home.
   assign credit        = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_C;
   assign mem_req       = nReset && (state_q == FETCH) && credit && !bus.Flush;
   assign grant         = mem_req && bus.MemGrant;
   assign rsp           = bus.MemRValid && (outstanding_q != '0);
   assign push          = rsp && (state_q != DRAIN) && !bus.Flush;
   assign instr_valid   = (count_q != '0);
   assign pop           = instr_valid && bus.InstrReady;
   assign in_flight_net = outstanding_q - CW'(rsp);

   always_comb begin
      outstanding_d = outstanding_q + CW'(grant) - CW'(rsp);
      count_d       = count_q + CW'(push) - CW'(pop);
      discard_d     = discard_q;
      state_d       = state_q;
      af_wr_d       = grant ? ptr_inc(af_wr_q) : af_wr_q;
      af_rd_d       = push  ? ptr_inc(af_rd_q) : af_rd_q;
      iq_wr_d       = push  ? ptr_inc(iq_wr_q) : iq_wr_q;
      iq_rd_d       = pop   ? ptr_inc(iq_rd_q) : iq_rd_q;
      credit_next   = ({1'b0, outstanding_d} + {1'b0, count_d}) < DEPTH_C;

      if (bus.Flush) begin
         count_d   = '0;
         af_wr_d   = '0;
         af_rd_d   = '0;
         iq_wr_d   = '0;
         iq_rd_d   = '0;
         discard_d = in_flight_net;
         state_d   = (in_flight_net != '0) ? DRAIN : FETCH;
      end else begin
         unique case (state_q)
            FETCH, STALL: state_d = credit_next ? FETCH : STALL;
            DRAIN: begin
               if (rsp) begin
                  discard_d = discard_q - CW'(1);
                  if (discard_q == CW'(1)) state_d = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_q       <= FETCH;
         outstanding_q <= '0;
         count_q       <= '0;
         discard_q     <= '0;
         af_wr_q       <= '0;
         af_rd_q       <= '0;
         iq_wr_q       <= '0;
         iq_rd_q       <= '0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         count_q       <= count_d;
         discard_q     <= discard_d;
         af_wr_q       <= af_wr_d;
         af_rd_q       <= af_rd_d;
         iq_wr_q       <= iq_wr_d;
         iq_rd_q       <= iq_rd_d;
      end
   end

   always_ff @(posedge Clock) begin
      if (grant) af_mem[af_wr_q] <= bus.PcValue;
      if (push) begin
         iq_data[iq_wr_q] <= bus.MemRData;
         iq_addr[iq_wr_q] <= af_mem[af_rd_q];
      end
   end

   assign bus.MemReq     = mem_req;
   assign bus.MemAddr    = bus.PcValue;
   assign bus.PcStep     = grant;
   assign bus.InstrValid = instr_valid;
   assign bus.Instr      = instr_valid ? iq_data[iq_rd_q] : '0;
   assign bus.InstrAddr  = instr_valid ? iq_addr[iq_rd_q] : '0;

   a_rvalid_in_flight: assert property (@(posedge Clock) disable iff (!nReset)
      bus.MemRValid |-> (outstanding_q != '0));

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ==== tb_instruction_fetch : directed scenarios against an in-order memory model and instruction scoreboard ====
// ==== Rev 1.0                                                                                              ====
module tb_instruction_fetch;
   localparam int WIDTH = 16;
   localparam int QD    = 2;

   typedef struct {
      logic [WIDTH-1:0] addr;
      logic [WIDTH-1:0] data;
      int               due;
   } mem_t;

   typedef struct {
      logic [WIDTH-1:0] addr;
      logic [WIDTH-1:0] data;
   } exp_t;

   logic Clock = 1'b0;
   logic nReset;

   instruction_fetch_if #(.WIDTH(WIDTH)) bus ();

   instruction_fetch #(.QUEUE_DEPTH(QD), .WIDTH(WIDTH)) dut (
      .Clock  (Clock),
      .nReset (nReset),
      .bus    (bus)
   );

   always #5 Clock = ~Clock;

   mem_t             mem_q[$];
   exp_t             exp_q[$];
   int               total = 0;
   int               bad = 0;
   int               cyc = 0;
   int               lat = 1;
   int               grants = 0;
   int               steps = 0;
   int               delivered = 0;
   int               g0;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] a_addr;

   function automatic logic [WIDTH-1:0] mem_word(input logic [WIDTH-1:0] a);
      return (a * 16'd7) ^ 16'hC35A;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs are applied just after the falling edge and outputs are observed 1ns later.
   task automatic drive(input logic fl, input logic gr, input logic rd);
      bus.Flush      = fl;
      bus.MemGrant   = gr;
      bus.InstrReady = rd;
      bus.PcValue    = pc;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         bus.MemRValid = 1'b1;
         bus.MemRData  = mem_q[0].data;
      end else begin
         bus.MemRValid = 1'b0;
         bus.MemRData  = '0;
      end
      #1;
   endtask

   task automatic advance();
      exp_t e;
      logic step_seen;
      if (bus.MemReq && bus.MemGrant) begin
         mem_q.push_back('{pc, mem_word(pc), cyc + lat});
         exp_q.push_back('{pc, mem_word(pc)});
         grants++;
      end
      if (bus.MemRValid) void'(mem_q.pop_front());
      if (bus.InstrValid && bus.InstrReady) begin
         delivered++;
         if (exp_q.size() == 0) begin
            total++;
            assert (exp_q.size() != 0) else begin
               bad++;
               $error("FAIL sb_unexpected observed=%0h expected=none", bus.InstrAddr);
            end
         end else begin
            e = exp_q.pop_front();
            check("sb_instr_addr", 32'(bus.InstrAddr), 32'(e.addr));
            check("sb_instr_data", 32'(bus.Instr), 32'(e.data));
         end
      end
      if (bus.Flush) exp_q.delete();
      step_seen = bus.PcStep;
      @(posedge Clock);
      if (step_seen) begin
         pc = pc + 16'd1;
         steps++;
      end
      cyc++;
      @(negedge Clock);
   endtask

   task automatic run(input int n, input logic fl, input logic gr, input logic rd);
      for (int i = 0; i < n; i++) begin
         drive(fl, gr, rd);
         advance();
      end
   endtask

   initial begin
      pc             = '0;
      nReset         = 1'b0;
      bus.Flush      = 1'b0;
      bus.MemGrant   = 1'b1;
      bus.InstrReady = 1'b1;
      bus.MemRValid  = 1'b0;
      bus.MemRData   = '0;
      bus.PcValue    = '0;

      // Reset state
      @(negedge Clock);
      drive(0, 1, 1);
      check("rst_memreq", 32'(bus.MemReq), 0);
      check("rst_pcstep", 32'(bus.PcStep), 0);
      check("rst_ivalid", 32'(bus.InstrValid), 0);
      check("rst_instr", 32'(bus.Instr), 0);
      check("rst_iaddr", 32'(bus.InstrAddr), 0);
      advance();

      // First cycle after release requests, response pushed one cycle later
      nReset = 1'b1;
      drive(0, 1, 1);
      check("rel_memreq", 32'(bus.MemReq), 1);
      check("rel_memaddr", 32'(bus.MemAddr), 32'h0000);
      check("rel_pcstep", 32'(bus.PcStep), 1);
      advance();
      drive(0, 1, 1);
      check("push_cycle_ivalid", 32'(bus.InstrValid), 0);
      advance();
      drive(0, 1, 1);
      check("lat1_ivalid", 32'(bus.InstrValid), 1);
      check("lat1_iaddr", 32'(bus.InstrAddr), 32'h0000);
      advance();

      // Streaming
      run(20, 0, 1, 1);
      run(4, 0, 0, 1);
      check("stream_delivered", 32'(delivered), 32'(grants));
      check("stream_steps", 32'(steps), 32'(grants));
      check("stream_sb_empty", 32'(exp_q.size()), 0);

      // Back-pressure
      g0 = grants;
      run(6, 0, 1, 0);
      check("bp_grants", 32'(grants - g0), 2);
      drive(0, 1, 0);
      check("bp_stall_memreq", 32'(bus.MemReq), 0);
      check("bp_ivalid", 32'(bus.InstrValid), 1);
      advance();
      drive(0, 1, 1);
      check("bp_pop_memreq", 32'(bus.MemReq), 0);
      advance();
      drive(0, 1, 1);
      check("bp_resume_memreq", 32'(bus.MemReq), 1);
      advance();
      run(6, 0, 0, 1);

      // Flush with two reads in flight
      lat = 3;
      run(2, 0, 1, 1);
      drive(0, 1, 1);
      check("fl_nocredit_memreq", 32'(bus.MemReq), 0);
      pc = 16'h0100;
      drive(1, 1, 1);
      check("fl_memreq", 32'(bus.MemReq), 0);
      advance();
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 1);
         check("drain_rvalid", 32'(bus.MemRValid), 1);
         check("drain_ivalid", 32'(bus.InstrValid), 0);
         check("drain_memreq", 32'(bus.MemReq), 0);
         advance();
      end
      lat = 1;
      drive(0, 1, 1);
      check("fl_resume_memreq", 32'(bus.MemReq), 1);
      check("fl_resume_addr", 32'(bus.MemAddr), 32'h0100);
      check("fl_resume_ivalid", 32'(bus.InstrValid), 0);
      advance();
      drive(0, 0, 1);
      advance();
      drive(0, 0, 1);
      check("fl_new_ivalid", 32'(bus.InstrValid), 1);
      check("fl_new_iaddr", 32'(bus.InstrAddr), 32'h0100);
      advance();
      run(4, 0, 0, 1);

      // Flush coinciding with a response and a decoder handshake
      lat    = 2;
      a_addr = pc;
      run(3, 0, 1, 0);
      drive(1, 1, 1);
      check("sim_rvalid", 32'(bus.MemRValid), 1);
      check("sim_ivalid", 32'(bus.InstrValid), 1);
      check("sim_iaddr", 32'(bus.InstrAddr), 32'(a_addr));
      check("sim_memreq", 32'(bus.MemReq), 0);
      advance();
      drive(0, 0, 1);
      check("sim_after_memreq", 32'(bus.MemReq), 1);
      check("sim_after_ivalid", 32'(bus.InstrValid), 0);
      advance();
      drive(0, 0, 1);
      check("sim_dropped_ivalid", 32'(bus.InstrValid), 0);
      advance();

      // Asynchronous reset between edges
      lat = 1;
      run(3, 0, 1, 0);
      drive(0, 1, 0);
      check("pre_rst_ivalid", 32'(bus.InstrValid), 1);
      check("pre_rst_memreq", 32'(bus.MemReq), 0);
      #2;
      nReset = 1'b0;
      #1;
      check("arst_memreq", 32'(bus.MemReq), 0);
      check("arst_pcstep", 32'(bus.PcStep), 0);
      check("arst_ivalid", 32'(bus.InstrValid), 0);
      check("arst_instr", 32'(bus.Instr), 0);
      check("arst_iaddr", 32'(bus.InstrAddr), 0);
      mem_q.delete();
      exp_q.delete();
      @(negedge Clock);
      drive(0, 1, 1);
      check("arst_hold_memreq", 32'(bus.MemReq), 0);
      advance();
      nReset = 1'b1;
      pc     = 16'h0200;
      drive(0, 1, 1);
      check("arst_rel_memreq", 32'(bus.MemReq), 1);
      check("arst_rel_addr", 32'(bus.MemAddr), 32'h0200);
      advance();

      // Slow memory: grant withheld for five cycles
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 1);
         check("slow_memreq", 32'(bus.MemReq), 1);
         check("slow_memaddr", 32'(bus.MemAddr), 32'h0201);
         check("slow_pcstep", 32'(bus.PcStep), 0);
         advance();
      end
      drive(0, 1, 1);
      check("slow_grant_pcstep", 32'(bus.PcStep), 1);
      advance();
      run(4, 0, 0, 1);
      check("final_sb_empty", 32'(exp_q.size()), 0);
      check("final_steps", 32'(steps), 32'(grants));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
